pixel_result_writer: RTL and testbench
======================================

# pixel_result_writer

Sink-side counterpart of the Sobel pipeline's beat/address sequencer: accepts the strobed pixel results that come out of the filter and writes them, in order, to the output frame buffer. A small FIFO absorbs output-memory stalls, and a write-address counter walks the frame from MINPIXEL to MAXPIXEL. The block pulses frameDone once the frame's final result is committed to memory.

## Interface
- MINPIXEL, 0: first output frame address.
- MAXPIXEL, 255: last output frame address (inclusive); frame length N = MAXPIXEL-MINPIXEL+1.
- PIXELCOUNTERWIDTH, 20: width of the address and count registers.
- DATAWIDTH, 8: result pixel width.
- FIFODEPTH, 4: buffer entries (power of 2, ≥2).

- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-low reset.
- startIn  input  1  frame start request, sampled in IDLE only.
- pixelValid  input  1  result strobe; one result per high cycle.
- pixelIn  input  DATAWIDTH  result data, qualified by pixelValid.
- memReady  input  1  frame buffer accepts a write this cycle.
- memWrEn  output  1  write request.
- memAddr  output  PIXELCOUNTERWIDTH  write address.
- memData  output  DATAWIDTH  write data (FIFO head).
- busy  output  1  high in RUN and FLUSH.
- frameDone  output  1  one-cycle pulse at end of frame.
- overflow  output  1  sticky: a result was dropped because the FIFO was full.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE → RUN when startIn = 1. On that edge: acceptCount ← 0, memAddr ← MINPIXEL, FIFO cleared, overflow ← 0.
- RUN: each pixelValid cycle is one accepted result, and acceptCount increments by 1.
  - When the FIFO has room, or is full with a pop in the same cycle, push pixelIn.
  - Otherwise drop the result and set overflow. A dropped result still counts toward N.
  - When the increment makes acceptCount reach N, go to FLUSH.
- FLUSH: pixelValid is ignored (no push, no count, no overflow). Go to DONE on the cycle the FIFO becomes empty through its last pop. If the FIFO is already empty on entry, go to DONE on the next cycle.
- DONE: frameDone = 1 for exactly one cycle, then IDLE.
- Write port:
  - memWrEn = FIFO non-empty AND state ∈ {RUN, FLUSH}.
  - A write commits when memWrEn and memReady are both high: pop the FIFO and increment memAddr by 1.
  - memAddr never passes MAXPIXEL. After the write at MAXPIXEL it holds MAXPIXEL until the next start.
- startIn outside IDLE is ignored.
- memData always shows the FIFO head. Its value is don't-care when memWrEn = 0, but it resets to 0.
- Arithmetic: all counters are unsigned PIXELCOUNTERWIDTH with no wrap inside a frame. FIFO pointers are log2(FIFODEPTH)+1 bits and wrap naturally; full/empty come from a pointer compare.

## Timing
- Reset values (async assert): state IDLE, memWrEn 0, memAddr MINPIXEL, memData 0, busy 0, frameDone 0, overflow 0, FIFO empty, acceptCount 0.
- Reset asserted mid-frame aborts immediately. There is no frameDone, and buffered data is discarded.
- Latency: pixelValid at edge k → memWrEn high in cycle k+1. With memReady high, the write commits at edge k+1.
- Throughput: 1 result/cycle sustained when memReady = 1. The upstream beat/pause pattern (e.g. 1111 0 1111 0) never fills the FIFO.
- A push and a pop in the same cycle leave the occupancy unchanged. On a full FIFO this is still a legal push.
- The last accepted pixel and the RUN→FLUSH transition share the same edge.
- frameDone is high in the cycle after the final pop. busy drops in that same cycle.

## Test plan
- Basic frame (MINPIXEL = 0, MAXPIXEL = 7, memReady = 1): pulse start, then 8 consecutive valids with data 0x10..0x17 → writes addr 0..7 with data 0x10..0x17, each one cycle after its valid. frameDone fires 2 cycles after the last valid, and overflow stays 0.
- Beat/pause input (pattern 11110, N = 8): → 8 writes in order, no overflow, and memWrEn low in the cycles following each pause.
- Backpressure: memReady = 0 for 3 cycles while 4 valids arrive (FIFODEPTH = 4) → FIFO full with no drop. The 5th valid, arriving while memReady = 1, is accepted through the simultaneous pop. All data is written in order, and overflow = 0.
- Overflow: memReady = 0 and 5 valids → the 5th is dropped and overflow = 1. The frame still ends after 8 accepted results, with only 7 writes. overflow clears on the next startIn.
- Extra valids and start in FLUSH/RUN: valids after the 8th and a startIn during RUN → no push, no extra writes, and the frame completes normally.
- Async reset mid-frame: assert reset after 3 writes → all outputs return to their reset values immediately. A new start then writes from addr 0.

Source files
------------

// File: rtl/pixel_result_writer_if.sv
// Result-stream and frame-buffer write bus for pixel_result_writer.
interface pixel_result_writer_if #(
  parameter int DATAWIDTH         = 8,
  parameter int PIXELCOUNTERWIDTH = 20
);
  logic                         pixelValid;
  logic [DATAWIDTH-1:0]         pixelIn;
  logic                         memReady;
  logic                         memWrEn;
  logic [PIXELCOUNTERWIDTH-1:0] memAddr;
  logic [DATAWIDTH-1:0]         memData;

  // Environment side: filter results in, frame buffer ready in
  modport master (
    output pixelValid, pixelIn, memReady,
    input  memWrEn, memAddr, memData
  );

  // Writer side
  modport slave (
    input  pixelValid, pixelIn, memReady,
    output memWrEn, memAddr, memData
  );
endinterface

// File: rtl/pixel_result_writer.sv
// Collects strobed Sobel results into a small FIFO and writes them in order
// to the output frame buffer from MINPIXEL to MAXPIXEL, pulsing frameDone
// once the last result of the frame has been committed.
module pixel_result_writer #(
  parameter int MINPIXEL          = 0,
  parameter int MAXPIXEL          = 255,
  parameter int PIXELCOUNTERWIDTH = 20,
  parameter int DATAWIDTH         = 8,
  parameter int FIFODEPTH         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startIn,
  pixel_result_writer_if.slave  bus,
  output logic                  busy,
  output logic                  frameDone,
  output logic                  overflow
);

  localparam int AW = $clog2(FIFODEPTH);
  localparam logic [PIXELCOUNTERWIDTH-1:0] MINADDR  = PIXELCOUNTERWIDTH'(MINPIXEL);
  localparam logic [PIXELCOUNTERWIDTH-1:0] MAXADDR  = PIXELCOUNTERWIDTH'(MAXPIXEL);
  localparam logic [PIXELCOUNTERWIDTH-1:0] FRAMELEN = PIXELCOUNTERWIDTH'(MAXPIXEL - MINPIXEL + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                   state;
  logic [PIXELCOUNTERWIDTH-1:0] acceptCount;
  logic [PIXELCOUNTERWIDTH-1:0] acceptNext;
  logic [PIXELCOUNTERWIDTH-1:0] memAddrReg;
  logic [DATAWIDTH-1:0]         fifoMem [FIFODEPTH];
  logic [AW:0]                  wrPtr;
  logic [AW:0]                  rdPtr;
  logic [AW:0]                  rdPtrNext;
  logic                         fifoEmpty;
  logic                         fifoFull;
  logic                         writeActive;
  logic                         pop;
  logic                         push;
  logic                         drop;
  logic                         lastPop;

  // FIFO status, write handshake and accept/drop decisions
  always_comb begin
    fifoEmpty   = (wrPtr == rdPtr);
    fifoFull    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    writeActive = ~fifoEmpty && ((state == RUN) || (state == FLUSH));
    pop         = writeActive && bus.memReady;
    rdPtrNext   = rdPtr + 1'b1;
    lastPop     = pop && (rdPtrNext == wrPtr);
    // A full FIFO still takes a result when the head leaves in the same cycle
    push        = (state == RUN) && bus.pixelValid && (~fifoFull || pop);
    drop        = (state == RUN) && bus.pixelValid && fifoFull && ~pop;
    acceptNext  = acceptCount + PIXELCOUNTERWIDTH'(1);
  end

  assign bus.memWrEn = writeActive;
  assign bus.memAddr = memAddrReg;
  assign bus.memData = fifoMem[rdPtr[AW-1:0]];
  assign busy        = (state == RUN) || (state == FLUSH);
  assign frameDone   = (state == DONE);

  // Frame sequencing, accept counting, write address and FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      acceptCount <= '0;
      memAddrReg  <= MINADDR;
      overflow    <= 1'b0;
      wrPtr       <= '0;
      rdPtr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startIn) begin
            state       <= RUN;
            acceptCount <= '0;
            memAddrReg  <= MINADDR;
            overflow    <= 1'b0;
            wrPtr       <= '0;
            rdPtr       <= '0;
          end
        end
        RUN: begin
          // Dropped results still count toward the frame length
          if (bus.pixelValid) begin
            acceptCount <= acceptNext;
            if (acceptNext == FRAMELEN) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (fifoEmpty || lastPop) state <= DONE;
        end
        default: state <= IDLE;
      endcase

      // push/pop only happen in RUN/FLUSH, so they never collide with the IDLE clear
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr <= rdPtrNext;
        if (memAddrReg != MAXADDR) memAddrReg <= memAddrReg + PIXELCOUNTERWIDTH'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // FIFO storage; cleared on reset so memData reads 0 out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFODEPTH; i++) fifoMem[i] <= '0;
    end else if (push) begin
      fifoMem[wrPtr[AW-1:0]] <= bus.pixelIn;
    end
  end

endmodule

// File: tb/tb_pixel_result_writer.sv
// Scoreboard bench for pixel_result_writer with an 8-pixel frame (addr 0..7).
module tb_pixel_result_writer;
  localparam int DW = 8;
  localparam int PW = 20;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic startIn;
  logic busy, frameDone, overflow;

  int tests = 0;
  int fails = 0;
  int writeCount = 0;
  int doneCount = 0;
  wr_t expQ[$];

  pixel_result_writer_if #(.DATAWIDTH(DW), .PIXELCOUNTERWIDTH(PW)) bus ();

  pixel_result_writer #(
    .MINPIXEL(0), .MAXPIXEL(7), .PIXELCOUNTERWIDTH(PW), .DATAWIDTH(DW), .FIFODEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .startIn(startIn), .bus(bus.slave),
    .busy(busy), .frameDone(frameDone), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every committed write is compared against the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (frameDone) doneCount++;
      if (bus.memWrEn && bus.memReady) begin
        writeCount++;
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h with empty scoreboard", bus.memAddr, bus.memData);
        end else begin
          wr_t e;
          e = expQ.pop_front();
          check("wr_addr", 32'(bus.memAddr), 32'(e.addr));
          check("wr_data", 32'(bus.memData), 32'(e.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startFrame();
    startIn = 1'b1;
    step();
    startIn = 1'b0;
    check("start_busy", busy, 1'b1);
  endtask

  // One valid cycle; expected write pushed only when the result is meant to land
  task automatic sendValid(input logic [7:0] d, input logic rdy, input logic lands, input int addr);
    bus.pixelValid = 1'b1;
    bus.pixelIn    = d;
    bus.memReady   = rdy;
    if (lands) expQ.push_back('{addr: PW'(addr), data: d});
    step();
    bus.pixelValid = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!frameDone && n < 40) begin
      step();
      n++;
    end
    check({name, "_frameDone"}, frameDone, 1'b1);
    check({name, "_busy_at_done"}, busy, 1'b0);
    step();
    check({name, "_done_pulse_end"}, frameDone, 1'b0);
  endtask

  initial begin
    int base;
    reset = 1'b0;
    startIn = 1'b0;
    bus.pixelValid = 1'b0;
    bus.pixelIn = '0;
    bus.memReady = 1'b1;
    #2;
    check("rst_memWrEn", bus.memWrEn, 1'b0);
    check("rst_memAddr", bus.memAddr, 0);
    check("rst_memData", bus.memData, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_frameDone", frameDone, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    #20 reset = 1'b1;
    step();

    // Basic frame: 8 back-to-back results, one write per cycle after each valid
    startFrame();
    for (int i = 0; i < 8; i++) begin
      sendValid(8'(8'h10 + i), 1'b1, 1'b1, i);
      check("basic_wren_next_cycle", bus.memWrEn, 1'b1);
      check("basic_addr_next_cycle", bus.memAddr, 32'(i));
    end
    check("basic_no_done_yet", frameDone, 1'b0);
    step();
    check("basic_done_2_after_last", frameDone, 1'b1);
    check("basic_busy_drop", busy, 1'b0);
    step();
    check("basic_done_one_cycle", frameDone, 1'b0);
    check("basic_overflow", overflow, 1'b0);
    check("basic_writes", writeCount, 8);
    check("basic_frames", doneCount, 1);
    check("basic_addr_hold", bus.memAddr, 7);

    // Beat/pause pattern 1111 0 1111
    startFrame();
    base = 0;
    for (int j = 0; j < 9; j++) begin
      if (j == 4) begin
        bus.pixelValid = 1'b0;
        step();
        check("beat_wren_after_pause", bus.memWrEn, 1'b0);
      end else begin
        sendValid(8'(8'h20 + base), 1'b1, 1'b1, base);
        base++;
      end
    end
    waitDone("beat");
    check("beat_overflow", overflow, 1'b0);
    check("beat_writes", writeCount, 16);

    // Backpressure: FIFO fills exactly, 5th result rides the simultaneous pop
    startFrame();
    for (int i = 0; i < 4; i++) sendValid(8'(8'h30 + i), 1'b0, 1'b1, i);
    check("bp_full_wren", bus.memWrEn, 1'b1);
    check("bp_overflow_full", overflow, 1'b0);
    for (int i = 4; i < 8; i++) sendValid(8'(8'h30 + i), 1'b1, 1'b1, i);
    waitDone("bp");
    check("bp_overflow", overflow, 1'b0);
    check("bp_writes", writeCount, 24);

    // Overflow: 5th result dropped, frame still ends after 8 accepted results
    startFrame();
    for (int i = 0; i < 5; i++) sendValid(8'(8'h40 + i), 1'b0, (i < 4), i);
    check("ovf_set", overflow, 1'b1);
    for (int i = 5; i < 8; i++) sendValid(8'(8'h40 + i), 1'b1, 1'b1, i - 1);
    waitDone("ovf");
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_writes", writeCount, 31);
    check("ovf_addr_end", bus.memAddr, 7);

    // Extra valids past the frame and a start request during RUN are ignored
    startFrame();
    check("ovf_cleared_on_start", overflow, 1'b0);
    for (int i = 0; i < 4; i++) sendValid(8'(8'h50 + i), 1'b1, 1'b1, i);
    startIn = 1'b1;
    sendValid(8'h54, 1'b1, 1'b1, 4);
    startIn = 1'b0;
    for (int i = 5; i < 8; i++) sendValid(8'(8'h50 + i), 1'b1, 1'b1, i);
    for (int i = 0; i < 3; i++) sendValid(8'hEE, 1'b1, 1'b0, 0);
    step();
    step();
    check("extra_writes", writeCount, 39);
    check("extra_frames", doneCount, 5);
    check("extra_idle", busy, 1'b0);
    check("extra_scoreboard_empty", expQ.size(), 0);

    // Async reset mid-frame, then a fresh frame from address 0
    startFrame();
    for (int i = 0; i < 4; i++) sendValid(8'(8'h60 + i), 1'b1, 1'b1, i);
    check("arst_three_writes", writeCount, 42);
    #2 reset = 1'b0;
    #1;
    check("arst_memWrEn", bus.memWrEn, 1'b0);
    check("arst_memAddr", bus.memAddr, 0);
    check("arst_memData", bus.memData, 0);
    check("arst_busy", busy, 1'b0);
    check("arst_frameDone", frameDone, 1'b0);
    expQ.delete();
    #4 reset = 1'b1;
    step();
    check("arst_no_done", doneCount, 5);
    startFrame();
    for (int i = 0; i < 8; i++) sendValid(8'(8'h70 + i), 1'b1, 1'b1, i);
    waitDone("post_rst");
    check("post_rst_writes", writeCount, 50);
    check("final_scoreboard_empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
